// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle MIPS controller (opcodes, functs, ALU codes, states).
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // Instruction opcodes, Instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function field, Instr[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes seen by data_path
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10
    } state_e;

    // True for the opcodes this controller executes; everything else retires as a no-op.
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multi_control_alu_decoder.sv
// Purpose: maps FSM ALUOp plus R-type funct to the data_path ALU control code.
// Latency: combinational, zero cycles.
// Backpressure: none.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    // Fixed add/sub for address and branch work; funct decode only for R-type execute
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    // Unknown funct still executes as add and writes back
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multi_control.sv
// Purpose: multicycle MIPS main controller (Moore FSM) sequencing data_path one instruction at a time.
// Latency: FETCH-to-FETCH lw 5, sw/R-type/addi 4, beq 3, unsupported opcode 2 cycles.
// Backpressure: none; advances every cycle. ST_W below 4 cannot hold the state codes and is not allowed.
module mips_multi_control
    import mips_ctrl_pkg::*;
#(
    parameter int ST_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCSrc,
    output logic       ALUSrcA,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       PCene,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUSControl,
    output logic       instr_done,
    output logic       illegal_op
);

    logic [ST_W-1:0] state;
    logic [1:0]      alu_op;

    // State register and next-state selection; unused codes fall back to FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_W'(S_FETCH);
        end else begin
            case (state)
                ST_W'(S_FETCH):  state <= ST_W'(S_DECODE);
                ST_W'(S_DECODE): begin
                    case (op)
                        OP_LW, OP_SW: state <= ST_W'(S_MEMADR);
                        OP_RTYPE:     state <= ST_W'(S_EXECUTE);
                        OP_BEQ:       state <= ST_W'(S_BRANCH);
                        OP_ADDI:      state <= ST_W'(S_ADDIEX);
                        default:      state <= ST_W'(S_FETCH);
                    endcase
                end
                ST_W'(S_MEMADR):  state <= (op == OP_LW) ? ST_W'(S_MEMRD) : ST_W'(S_MEMWR);
                ST_W'(S_MEMRD):   state <= ST_W'(S_MEMWB);
                ST_W'(S_EXECUTE): state <= ST_W'(S_ALUWB);
                ST_W'(S_ADDIEX):  state <= ST_W'(S_ADDIWB);
                default:          state <= ST_W'(S_FETCH);
            endcase
        end
    end

    // Moore output decode; only DECODE looks at op and only BRANCH looks at Zero
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        PCene      = 1'b0;
        ALUSrcB    = SRCB_REG;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            ST_W'(S_FETCH): begin
                IRWrite = 1'b1;
                PCene   = 1'b1;
                ALUSrcB = SRCB_FOUR;
            end
            ST_W'(S_DECODE): begin
                // Branch target lands in ALUOut whether or not it is a beq
                ALUSrcB = SRCB_IMM;
                if (!op_supported(op)) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_W'(S_MEMADR), ST_W'(S_ADDIEX): begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_W'(S_MEMRD): IorD = 1'b1;
            ST_W'(S_MEMWB): begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_W'(S_MEMWR): begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_W'(S_EXECUTE): begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            ST_W'(S_ALUWB): begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_W'(S_BRANCH): begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                PCSrc      = 1'b1;
                PCene      = Zero;
                instr_done = 1'b1;
            end
            ST_W'(S_ADDIWB): begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    mips_alu_decoder u_alu_dec (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (ALUSControl)
    );

endmodule

// File: tb/tb_mips_multi_control.sv
module tb_mips_multi_control;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegWrite, PCSrc, ALUSrcA, MemtoReg, RegDst, PCene;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUSControl;
    logic       instr_done, illegal_op;

    int n_cmp;
    int n_bad;
    int excl_viol;

    // {IorD,MemWrite,IRWrite,RegWrite, PCSrc,ALUSrcA,MemtoReg,RegDst, PCene, ALUSrcB, ALUSControl, instr_done, illegal_op}
    logic [15:0] ctrl;
    assign ctrl = {IorD, MemWrite, IRWrite, RegWrite, PCSrc, ALUSrcA, MemtoReg, RegDst,
                   PCene, ALUSrcB, ALUSControl, instr_done, illegal_op};

    localparam logic [15:0] V_FETCH  = 16'b0010_0000_1_01_010_00;
    localparam logic [15:0] V_DEC    = 16'b0000_0000_0_10_010_00;
    localparam logic [15:0] V_DECILL = 16'b0000_0000_0_10_010_11;
    localparam logic [15:0] V_MEMADR = 16'b0000_0100_0_10_010_00;
    localparam logic [15:0] V_MEMRD  = 16'b1000_0000_0_00_010_00;
    localparam logic [15:0] V_MEMWB  = 16'b0001_0010_0_00_010_10;
    localparam logic [15:0] V_MEMWR  = 16'b1100_0000_0_00_010_10;
    localparam logic [15:0] V_ALUWB  = 16'b0001_0001_0_00_010_10;
    localparam logic [15:0] V_ADDIEX = 16'b0000_0100_0_10_010_00;
    localparam logic [15:0] V_ADDIWB = 16'b0001_0000_0_00_010_10;

    mips_multi_control #(.ST_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .PCene(PCene), .ALUSrcB(ALUSrcB), .ALUSControl(ALUSControl),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (MemWrite && RegWrite) excl_viol++;
        if (IRWrite && dut.state !== 4'd0) excl_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (dut.state !== 4'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", dut.state); end
        n_cmp++;
        if (ctrl !== V_FETCH) begin n_bad++; $display("FAIL reset_ctrl got %b want %b", ctrl, V_FETCH); end
        // Walk lw into MEMRD, then hit reset there
        op = 6'b100011; funct = 6'd0; Zero = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (dut.state !== 4'd3) begin n_bad++; $display("FAIL reset_pre_memrd got %0d want 3", dut.state); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (dut.state !== 4'd0) begin n_bad++; $display("FAIL reset_async got %0d want 0", dut.state); end
        n_cmp++;
        if (ctrl !== V_FETCH) begin n_bad++; $display("FAIL reset_async_ctrl got %b want %b", ctrl, V_FETCH); end
        tick();
        n_cmp++;
        if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            n_bad++; $display("FAIL reset_hold_strobes got rw=%b mw=%b want 0 0", RegWrite, MemWrite);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctrl !== V_FETCH) begin n_bad++; $display("FAIL reset_release_ctrl got %b want %b", ctrl, V_FETCH); end
        tick();
        n_cmp++;
        if (dut.state !== 4'd1) begin n_bad++; $display("FAIL reset_resume got %0d want 1", dut.state); end
        tick(); tick(); tick(); tick();
        n_cmp++;
        if (dut.state !== 4'd0) begin n_bad++; $display("FAIL reset_resume_end got %0d want 0", dut.state); end
    endtask

    task automatic test_lw();
        logic [3:0]  es [5];
        logic [15:0] ev [5];
        int dones;
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        ev = '{V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB};
        op = 6'b100011; funct = 6'd0; Zero = 1'b0; dones = 0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (dut.state !== es[i]) begin n_bad++; $display("FAIL lw_state c%0d got %0d want %0d", i, dut.state, es[i]); end
            n_cmp++;
            if (ctrl !== ev[i]) begin n_bad++; $display("FAIL lw_ctrl c%0d got %b want %b", i, ctrl, ev[i]); end
            dones += int'(instr_done);
            tick();
        end
        n_cmp++;
        if (dut.state !== 4'd0) begin n_bad++; $display("FAIL lw_return got %0d want 0", dut.state); end
        n_cmp++;
        if (dones != 1) begin n_bad++; $display("FAIL lw_done_count got %0d want 1", dones); end
    endtask

    task automatic test_sw();
        logic [3:0]  es [4];
        logic [15:0] ev [4];
        es = '{4'd0, 4'd1, 4'd2, 4'd5};
        ev = '{V_FETCH, V_DEC, V_MEMADR, V_MEMWR};
        op = 6'b101011; funct = 6'd0; Zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut.state !== es[i]) begin n_bad++; $display("FAIL sw_state c%0d got %0d want %0d", i, dut.state, es[i]); end
            n_cmp++;
            if (ctrl !== ev[i]) begin n_bad++; $display("FAIL sw_ctrl c%0d got %b want %b", i, ctrl, ev[i]); end
            tick();
        end
        n_cmp++;
        if (dut.state !== 4'd0) begin n_bad++; $display("FAIL sw_return got %0d want 0", dut.state); end
    endtask

    task automatic test_rtype();
        logic [5:0] fn [6];
        logic [2:0] ac [6];
        logic [15:0] ev [4];
        fn = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b110000};
        ac = '{3'b110,    3'b010,    3'b000,    3'b001,    3'b111,    3'b010};
        op = 6'b000000; Zero = 1'b0;
        for (int k = 0; k < 6; k++) begin
            funct = fn[k];
            ev = '{V_FETCH, V_DEC, {8'b0000_0100, 1'b0, 2'b00, ac[k], 2'b00}, V_ALUWB};
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (dut.state !== (i == 0 ? 4'd0 : i == 1 ? 4'd1 : i == 2 ? 4'd6 : 4'd7)) begin
                    n_bad++; $display("FAIL rtype_state f%b c%0d got %0d", fn[k], i, dut.state);
                end
                n_cmp++;
                if (ctrl !== ev[i]) begin n_bad++; $display("FAIL rtype_ctrl f%b c%0d got %b want %b", fn[k], i, ctrl, ev[i]); end
                tick();
            end
        end
        n_cmp++;
        if (dut.state !== 4'd0) begin n_bad++; $display("FAIL rtype_return got %0d want 0", dut.state); end
    endtask

    task automatic test_beq();
        logic [15:0] vb;
        op = 6'b000100; funct = 6'd0;
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            vb = {8'b0000_1100, z[0], 7'b00_110_10};
            n_cmp++;
            if (ctrl !== V_FETCH) begin n_bad++; $display("FAIL beq_fetch z%0d got %b want %b", z, ctrl, V_FETCH); end
            tick();
            n_cmp++;
            if (ctrl !== V_DEC) begin n_bad++; $display("FAIL beq_decode z%0d got %b want %b", z, ctrl, V_DEC); end
            tick();
            n_cmp++;
            if (dut.state !== 4'd8) begin n_bad++; $display("FAIL beq_state z%0d got %0d want 8", z, dut.state); end
            n_cmp++;
            if (ctrl !== vb) begin n_bad++; $display("FAIL beq_ctrl z%0d got %b want %b", z, ctrl, vb); end
            // PCene follows Zero within the cycle
            Zero = ~z[0];
            #1;
            n_cmp++;
            if (PCene !== ~z[0]) begin n_bad++; $display("FAIL beq_zero_comb z%0d got %b want %b", z, PCene, ~z[0]); end
            Zero = z[0];
            tick();
            n_cmp++;
            if (dut.state !== 4'd0) begin n_bad++; $display("FAIL beq_return z%0d got %0d want 0", z, dut.state); end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        ops = '{6'b111111, 6'b000010};
        funct = 6'd0; Zero = 1'b1;
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            tick();
            n_cmp++;
            if (ctrl !== V_DECILL) begin n_bad++; $display("FAIL illegal_decode op%b got %b want %b", ops[k], ctrl, V_DECILL); end
            tick();
            n_cmp++;
            if (dut.state !== 4'd0) begin n_bad++; $display("FAIL illegal_return op%b got %0d want 0", ops[k], dut.state); end
        end
    endtask

    task automatic test_back_to_back();
        // addi then sw with no gap
        logic [3:0]  es [8];
        logic [15:0] ev [8];
        es = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd1, 4'd2, 4'd5};
        ev = '{V_FETCH, V_DEC, V_ADDIEX, V_ADDIWB, V_FETCH, V_DEC, V_MEMADR, V_MEMWR};
        funct = 6'd0; Zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            op = (i < 4) ? 6'b001000 : 6'b101011;
            #1;
            n_cmp++;
            if (dut.state !== es[i]) begin n_bad++; $display("FAIL b2b_state c%0d got %0d want %0d", i, dut.state, es[i]); end
            n_cmp++;
            if (ctrl !== ev[i]) begin n_bad++; $display("FAIL b2b_ctrl c%0d got %b want %b", i, ctrl, ev[i]); end
            tick();
        end
        n_cmp++;
        if (excl_viol != 0) begin n_bad++; $display("FAIL strobe_exclusive got %0d violations want 0", excl_viol); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; excl_viol = 0;
        rst = 1'b1; op = 6'd0; funct = 6'd0; Zero = 1'b0;
        #12;
        rst = 1'b0;
        #2;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
